// File: rtl/hs_unit_ce_gen_if.sv
// Control/strobe bundle for hs_unit_ce_gen; the phase field exists only when
// HS_UNIT_CE_GEN_PRELOAD_EN is defined.
interface hs_unit_ce_gen_if #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 stop;
  logic                 mode;
  logic                 en;
  logic [ACC_WIDTH-1:0] inc;
  logic [CNT_WIDTH-1:0] burst_len;
`ifdef HS_UNIT_CE_GEN_PRELOAD_EN
  logic [ACC_WIDTH-1:0] phase;
`endif
  logic                 ce;
  logic                 busy;
  logic                 done;

  modport master (
    output start, stop, mode, en, inc, burst_len,
`ifdef HS_UNIT_CE_GEN_PRELOAD_EN
    output phase,
`endif
    input  ce, busy, done
  );

  modport slave (
    input  start, stop, mode, en, inc, burst_len,
`ifdef HS_UNIT_CE_GEN_PRELOAD_EN
    input  phase,
`endif
    output ce, busy, done
  );
endinterface

// File: rtl/hs_unit_ce_gen.sv
// NCO clock-enable strobe generator (continuous or N-pulse burst), all outputs registered,
// first accumulate one edge after start, en=0 pauses. Optional acc preload: HS_UNIT_CE_GEN_PRELOAD_EN.
module hs_unit_ce_gen #(
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              sresetn,
  hs_unit_ce_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 ce_q, ce_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] start_acc;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry = sum[ACC_WIDTH];

`ifdef HS_UNIT_CE_GEN_PRELOAD_EN
  assign start_acc = bus.phase;
`else
  assign start_acc = '0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    inc_d       = inc_q;
    remaining_d = remaining_q;
    ce_d        = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        // stop beats start, including the zero-length burst case
        if (bus.start && !bus.stop) begin
          if (!bus.mode) begin
            inc_d   = bus.inc;
            acc_d   = start_acc;
            state_d = ST_RUN;
          end else if (bus.burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            inc_d       = bus.inc;
            acc_d       = start_acc;
            remaining_d = bus.burst_len;
            state_d     = ST_BURST;
          end
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          acc_d   = '0;
        end else if (bus.en) begin
          acc_d = sum[ACC_WIDTH-1:0];
          ce_d  = carry;
        end
      end

      ST_BURST: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          acc_d   = '0;
        end else if (bus.en) begin
          acc_d = sum[ACC_WIDTH-1:0];
          ce_d  = carry;
          if (carry) begin
            if (remaining_q == CNT_WIDTH'(1)) begin
              remaining_d = '0;
              done_d      = 1'b1;
              state_d     = ST_IDLE;
              acc_d       = '0;
            end else begin
              remaining_d = remaining_q - CNT_WIDTH'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      inc_q       <= '0;
      remaining_q <= '0;
      ce_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      remaining_q <= remaining_d;
      ce_q        <= ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ce   = ce_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_hs_unit_ce_gen.sv
// Directed-vector bench for hs_unit_ce_gen (ACC_WIDTH = CNT_WIDTH = 16).
// Preload vectors run only when HS_UNIT_CE_GEN_PRELOAD_EN is defined.
module tb_hs_unit_ce_gen;

  localparam int AW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic sresetn;
  int   n_cmp = 0;
  int   n_err = 0;

  hs_unit_ce_gen_if #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  hs_unit_ce_gen #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .sresetn (sresetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode      = 1'b0;
    bus.en        = 1'b1;
    bus.inc       = 16'h4000;
    bus.burst_len = 16'd0;
`ifdef HS_UNIT_CE_GEN_PRELOAD_EN
    bus.phase     = 16'h0000;
`endif
  endtask

  task automatic do_start(input logic m, input logic [AW-1:0] i, input logic [CW-1:0] n);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.inc       = i;
    bus.burst_len = n;
    step();
    bus.start     = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  int ce_cnt;

  initial begin
    idle_inputs();
    sresetn = 1'b0;
    #2;

    // Reset held with start asserted
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_ce", bus.ce, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
    end
    bus.start = 1'b0;
    sresetn   = 1'b1;
    step();
    check("rel_ce", bus.ce, 1'b0);
    check("rel_busy", bus.busy, 1'b0);
    check("rel_done", bus.done, 1'b0);

    // Continuous, inc = 1/4: ce on accumulate edges 4, 8, 12 ...
    do_start(1'b0, 16'h4000, 16'd0);
    check("run_busy_start", bus.busy, 1'b1);
    check("run_ce_start", bus.ce, 1'b0);
    ce_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      bus.inc = 16'h0001;   // must be ignored while busy
      step();
      check($sformatf("run_ce_%0d", k), bus.ce, (k % 4 == 0) ? 1'b1 : 1'b0);
      if (bus.ce) ce_cnt++;
    end
    check("run_ce_count", ce_cnt, 25);
    check("run_busy", bus.busy, 1'b1);
    do_stop();
    check("stop_ce", bus.ce, 1'b0);
    check("stop_busy", bus.busy, 1'b0);
    check("stop_done", bus.done, 1'b0);

    // Burst of 3, inc = 1/2: ce 0,1,0,1,0,1, done with the third
    do_start(1'b1, 16'h8000, 16'd3);
    check("bst_busy_start", bus.busy, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) begin
        bus.start     = 1'b1;
        bus.mode      = 1'b0;
        bus.inc       = 16'h1000;
        bus.burst_len = 16'd9;
      end
      step();
      bus.start = 1'b0;
      check($sformatf("bst_ce_%0d", k), bus.ce, k[0] ? 1'b0 : 1'b1);
      check($sformatf("bst_done_%0d", k), bus.done, (k == 6) ? 1'b1 : 1'b0);
      check($sformatf("bst_busy_%0d", k), bus.busy, (k == 6) ? 1'b0 : 1'b1);
    end
    step();
    check("bst_after_busy", bus.busy, 1'b0);
    check("bst_after_ce", bus.ce, 1'b0);
    check("bst_after_done", bus.done, 1'b0);

    // Pause right after the first ce
    do_start(1'b0, 16'h4000, 16'd0);
    for (int k = 1; k <= 4; k++) step();
    check("pse_first_ce", bus.ce, 1'b1);
    bus.en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("pse_hold_ce_%0d", k), bus.ce, 1'b0);
    end
    check("pse_busy", bus.busy, 1'b1);
    bus.en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("pse_resume_ce_%0d", k), bus.ce, (k == 4) ? 1'b1 : 1'b0);
    end
    do_stop();
    check("pse_stop_busy", bus.busy, 1'b0);

    // Zero-length burst: lone done, never busy
    do_start(1'b1, 16'h8000, 16'd0);
    check("z_done", bus.done, 1'b1);
    check("z_ce", bus.ce, 1'b0);
    check("z_busy", bus.busy, 1'b0);
    step();
    check("z_done_clr", bus.done, 1'b0);
    check("z_busy_after", bus.busy, 1'b0);

    // start together with stop
    bus.stop = 1'b1;
    do_start(1'b1, 16'h8000, 16'd0);
    bus.stop = 1'b0;
    check("ss_busy", bus.busy, 1'b0);
    check("ss_done", bus.done, 1'b0);
    step();
    check("ss_busy2", bus.busy, 1'b0);

    // inc = 0 never produces ce
    do_start(1'b0, 16'h0000, 16'd0);
    ce_cnt = 0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (bus.ce) ce_cnt++;
    end
    check("inc0_ce_count", ce_cnt, 0);
    check("inc0_busy", bus.busy, 1'b1);
    do_stop();

    // inc = max: first edge no carry, then carry on every edge for a long run
    do_start(1'b0, 16'hFFFF, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("max_ce_%0d", k), bus.ce, (k == 1) ? 1'b0 : 1'b1);
    end
    do_stop();

    // Reset mid-burst: everything clears, no done
    do_start(1'b1, 16'h8000, 16'd5);
    step();
    step();
    sresetn = 1'b0;
    step();
    sresetn = 1'b1;
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_ce", bus.ce, 1'b0);
    check("mrst_done", bus.done, 1'b0);
    step();
    check("mrst_busy2", bus.busy, 1'b0);

`ifdef HS_UNIT_CE_GEN_PRELOAD_EN
    // Preload phase 3/4: ce on accumulate edges 1, 5, 9 ...
    bus.phase = 16'hC000;
    do_start(1'b0, 16'h4000, 16'd0);
    bus.phase = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("pre_ce_%0d", k), bus.ce, (k % 4 == 1) ? 1'b1 : 1'b0);
    end
    do_stop();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
